pfb_bin_serializer: RTL and testbench
=====================================

Name: pfb_bin_serializer

Overview:
- Sits directly after the FFT of the oversampled PFB channelizer.
- Captures each complete frame of NOF_CHANNEL complex bins, presented in parallel on one cycle, into a ping-pong buffer.
- Reads each frame out as NOF_CHANNEL/BINS_PER_BEAT beats on a valid/ready stream toward packetiser/DMA logic.
- Flags and counts frames dropped because both buffers are full.

Parameters:
- DATA_WIDTH, 16, bits per real or imaginary component.
- NOF_CHANNEL, 64, bins per frame; must be a multiple of BINS_PER_BEAT.
- BINS_PER_BEAT, 16, complex bins per output beat; power of two.
- DROP_CNT_WIDTH, 16, width of the saturating dropped-frame counter.

Ports:
- clk_data  in  1  processing clock.
- rst  in  1  reset, asynchronous, active-high.
- din_real  in  DATA_WIDTH*NOF_CHANNEL  real parts; bin k at [k*DATA_WIDTH +: DATA_WIDTH].
- din_imag  in  DATA_WIDTH*NOF_CHANNEL  imaginary parts; same layout.
- din_valid  in  1  single-cycle strobe: whole frame present.
- dout  out  2*DATA_WIDTH*BINS_PER_BEAT  beat; bin j at [j*2W +: 2W], real in low W bits, imag in high W bits.
- dout_valid  out  1  beat available.
- dout_ready  in  1  sink accepts beat.
- dout_first  out  1  first beat of frame (bins 0..BINS_PER_BEAT-1).
- dout_last  out  1  last beat of frame.
- dout_chan  out  clog2(NOF_CHANNEL)  index of bin 0 of current beat.
- ovf_clr  in  1  synchronous clear of overflow and drop_cnt.
- overflow  out  1  sticky: at least one frame dropped.
- drop_cnt  out  DROP_CNT_WIDTH  saturating dropped-frame count.

Behaviour:
- Reset: all outputs 0, occupancy 0, write pointer 0, read pointer 0, beat counter 0. Buffer contents are don't-care.
- Reset mid-frame: the in-flight frame and the buffered frame are discarded. No partial beat resumes after rst deasserts.
- Storage: two frame buffers. wr_sel selects the buffer for the next capture, rd_sel the buffer being read, occ in 0..2.
- Capture: on din_valid with occ<2, the frame is written to buffer wr_sel, wr_sel toggles and occ increments.
- Read FSM, two states:
  - IDLE: dout_valid=0; moves to SEND when occ>0.
  - SEND: dout_valid=1. On each accepted beat (dout_valid && dout_ready), beat increments.
  - After the last beat is accepted: beat←0, rd_sel toggles, occ decrements. FSM stays in SEND if occ remains >0 after the update, otherwise returns to IDLE.
- Latency: a frame captured at edge T into an empty block gives dout_valid=1, dout_first=1 at edge T+1.
  - Back-to-back frames: the first beat of the next frame follows the last beat of the previous one with zero bubbles.
- Outputs: dout, first, last and chan are driven from registered buffer/beat state only. There is no combinational path from din_* to any output.
  - dout_chan = beat*BINS_PER_BEAT.
  - dout_first = (beat==0). dout_last = (beat==NOF_CHANNEL/BINS_PER_BEAT-1).
  - With 1 beat per frame, first and last are both 1.
- Stall: while dout_valid && !dout_ready, dout/first/last/chan hold stable. dout_valid never deasserts without acceptance.
- Full boundary, occ==2 and din_valid:
  - Normally the new frame is dropped, overflow←1 and drop_cnt increments, saturating at all-ones.
  - If the last beat is accepted in the same cycle, the freed buffer takes the new frame and nothing is dropped. occ stays 2.
- Simultaneous ovf_clr and drop: the clear wins the counter reset, but the drop is recorded (overflow=1, drop_cnt=1).
- Throughput: the frame period must be ≥ NOF_CHANNEL/BINS_PER_BEAT cycles for lossless operation. At a 2-cycle oversampled frame period, 16 bins per beat drops frames by design; integrators set BINS_PER_BEAT ≥ 32.
- No arithmetic on data: bins are passed bit-exact; real/imag are only packed.

Decomposition:
- Shared package: beat-count constant NOF_CHANNEL/BINS_PER_BEAT; clog2 function (the team's common one); complex bin packing convention (real low, imag high); FSM state encoding IDLE=0, SEND=1.
- One natural sub-module: pfb_frame_pingpong. It holds the two buffers, wr_sel/rd_sel/occ and the drop logic, and exposes a registered beat-select read port. The top level keeps the read FSM, beat counter and sideband outputs.

Test Plan:
- Reset, then one frame with bin k real=k, imag=-k, dout_ready=1 → 4 beats on consecutive cycles starting 1 cycle after din_valid.
  - Beat 0: chan=0, first=1, bin0=(0,0).
  - Beat 3: chan=48, last=1, bin15=(63,-63).
- Same frame, dout_ready toggled 1,0,1,0 → each beat held stable across stalls; 4 accepts over 8 cycles; data identical to the no-stall case.
- Three frames (A,B,C) on cycles 0,1,2 with dout_ready=0 → A and B buffered, C dropped; overflow=1, drop_cnt=1; releasing ready outputs A then B with no bubble.
- occ=2 and A's last beat accepted on the same cycle din_valid brings frame C → no drop; output order A,B,C; overflow stays 0.
- drop_cnt at 0xFFFF plus another drop → stays 0xFFFF.
  - Then ovf_clr alone → overflow=0, drop_cnt=0.
  - ovf_clr coincident with a drop → drop_cnt=1.
- Assert rst during beat 2 of a frame, with a second frame buffered → outputs 0 immediately; after release no beats appear until a new din_valid arrives.

Source files
------------

// File: rtl/pfb_bin_serializer_pkg.sv
// Shared definitions for the PFB bin serializer: default sizes, beat count,
// clog2, the complex bin packing convention and the read FSM encoding.
// No ports; imported by pfb_bin_serializer and pfb_frame_pingpong.
package pfb_bin_serializer_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_NOF_CHANNEL    = 64;
  localparam int DEF_BINS_PER_BEAT  = 16;
  localparam int DEF_DROP_CNT_WIDTH = 16;

  // A packed complex bin is {imag, real}: real in the low slot.
  localparam int BIN_REAL_SLOT = 0;
  localparam int BIN_IMAG_SLOT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  function automatic int beats_per_frame(input int nof_channel, input int bins_per_beat);
    return nof_channel / bins_per_beat;
  endfunction

endpackage

// File: rtl/pfb_frame_pingpong.sv
// Two-frame ping-pong store with wr_sel/rd_sel/occ bookkeeping and drop accounting.
// Ports: din_real/din_imag/din_valid capture a whole frame; frame_done releases the
// buffer being read; rd_beat selects the beat on rd_data; overflow/drop_cnt report drops.
module pfb_frame_pingpong
  import pfb_bin_serializer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NOF_CHANNEL    = DEF_NOF_CHANNEL,
  parameter int BINS_PER_BEAT  = DEF_BINS_PER_BEAT,
  parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH,
  parameter int BEAT_W         = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH*NOF_CHANNEL-1:0]     din_real,
  input  logic [DATA_WIDTH*NOF_CHANNEL-1:0]     din_imag,
  input  logic                                  din_valid,
  input  logic                                  frame_done,
  input  logic [BEAT_W-1:0]                     rd_beat,
  input  logic                                  ovf_clr,
  output logic [1:0]                            occ,
  output logic [1:0]                            occ_nxt,
  output logic [2*DATA_WIDTH*BINS_PER_BEAT-1:0] rd_data,
  output logic                                  overflow,
  output logic [DROP_CNT_WIDTH-1:0]             drop_cnt
);

  localparam int BIN_BITS   = 2 * DATA_WIDTH;
  localparam int BEAT_BITS  = BIN_BITS * BINS_PER_BEAT;
  localparam int FRAME_BITS = BIN_BITS * NOF_CHANNEL;

  logic [FRAME_BITS-1:0] mem [2];
  logic [FRAME_BITS-1:0] frame;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  capture;
  logic                  drop;

  // When full, the buffer being read is reusable on the cycle its last beat
  // is accepted (wr_sel == rd_sel then), so the new frame goes straight into it.
  assign capture = din_valid && ((occ != 2'd2) || frame_done);
  assign drop    = din_valid && !capture;
  assign occ_nxt = occ + {1'b0, capture} - {1'b0, frame_done};

  always_comb begin
    frame = '0;
    for (int k = 0; k < NOF_CHANNEL; k++) begin
      frame[k*BIN_BITS + BIN_REAL_SLOT*DATA_WIDTH +: DATA_WIDTH] = din_real[k*DATA_WIDTH +: DATA_WIDTH];
      frame[k*BIN_BITS + BIN_IMAG_SLOT*DATA_WIDTH +: DATA_WIDTH] = din_imag[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Frame storage needs no reset; occ decides what is meaningful.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_sel] <= frame;
  end

  // Read port addressed only by registered state (rd_sel, rd_beat).
  assign rd_data = mem[rd_sel][rd_beat*BEAT_BITS +: BEAT_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      occ      <= 2'd0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (capture)    wr_sel <= ~wr_sel;
      if (frame_done) rd_sel <= ~rd_sel;
      occ <= occ_nxt;
      // A clear coinciding with a drop still records that drop.
      if (ovf_clr) begin
        overflow <= drop;
        drop_cnt <= drop ? DROP_CNT_WIDTH'(1) : '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pfb_bin_serializer.sv
// Serializes parallel FFT frames into NOF_CHANNEL/BINS_PER_BEAT valid/ready beats.
// Ports: din_* + din_valid frame in; dout/dout_valid/dout_ready stream out with
// dout_first/dout_last/dout_chan sideband; ovf_clr clears overflow/drop_cnt.
module pfb_bin_serializer
  import pfb_bin_serializer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NOF_CHANNEL    = DEF_NOF_CHANNEL,
  parameter int BINS_PER_BEAT  = DEF_BINS_PER_BEAT,
  parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
  input  logic                                  clk_data,
  input  logic                                  rst,
  input  logic [DATA_WIDTH*NOF_CHANNEL-1:0]     din_real,
  input  logic [DATA_WIDTH*NOF_CHANNEL-1:0]     din_imag,
  input  logic                                  din_valid,
  output logic [2*DATA_WIDTH*BINS_PER_BEAT-1:0] dout,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic                                  dout_first,
  output logic                                  dout_last,
  output logic [clog2(NOF_CHANNEL)-1:0]         dout_chan,
  input  logic                                  ovf_clr,
  output logic                                  overflow,
  output logic [DROP_CNT_WIDTH-1:0]             drop_cnt
);

  localparam int NOF_BEATS = beats_per_frame(NOF_CHANNEL, BINS_PER_BEAT);
  localparam int BEAT_W    = (NOF_BEATS > 1) ? clog2(NOF_BEATS) : 1;
  localparam int CHAN_W    = clog2(NOF_CHANNEL);
  localparam int BPB_LOG   = clog2(BINS_PER_BEAT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NOF_BEATS - 1);

  rd_state_e                             state_q;
  rd_state_e                             state_d;
  logic [BEAT_W-1:0]                     beat_q;
  logic [BEAT_W-1:0]                     beat_d;
  logic                                  frame_done;
  logic [1:0]                            occ;
  logic [1:0]                            occ_nxt;
  logic [2*DATA_WIDTH*BINS_PER_BEAT-1:0] beat_data;
  logic                                  sending;

  pfb_frame_pingpong #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NOF_CHANNEL   (NOF_CHANNEL),
    .BINS_PER_BEAT (BINS_PER_BEAT),
    .DROP_CNT_WIDTH(DROP_CNT_WIDTH),
    .BEAT_W        (BEAT_W)
  ) u_pingpong (
    .clk       (clk_data),
    .rst       (rst),
    .din_real  (din_real),
    .din_imag  (din_imag),
    .din_valid (din_valid),
    .frame_done(frame_done),
    .rd_beat   (beat_q),
    .ovf_clr   (ovf_clr),
    .occ       (occ),
    .occ_nxt   (occ_nxt),
    .rd_data   (beat_data),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (occ != 2'd0) state_d = SEND;
      end
      SEND: begin
        if (dout_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d     = '0;
            frame_done = 1'b1;
            // Staying in SEND when another frame is queued gives zero bubbles.
            if (occ_nxt == 2'd0) state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sideband and data are qualified by SEND so everything reads 0 when idle or in reset.
  assign sending    = (state_q == SEND);
  assign dout_valid = sending;
  assign dout       = sending ? beat_data : '0;
  assign dout_first = sending && (beat_q == '0);
  assign dout_last  = sending && (beat_q == LAST_BEAT);
  assign dout_chan  = sending ? (CHAN_W'(beat_q) << BPB_LOG) : '0;

endmodule

// File: tb/tb_pfb_bin_serializer.sv
module tb_pfb_bin_serializer;

  localparam int DW   = 16;
  localparam int NCH  = 64;
  localparam int BPB  = 16;
  localparam int NB   = NCH / BPB;
  localparam int DCW  = 16;
  localparam int BEAT_BITS = 2 * DW * BPB;

  typedef logic [511:0] v_t;

  typedef struct {
    logic [DW-1:0] re [NCH];
    logic [DW-1:0] im [NCH];
  } frame_t;

  typedef struct {
    int dv, tag, rdy, ev, ef, el, ch, etag, ovf, drop;
  } row_t;

  logic                   clk_data;
  logic                   rst;
  logic [DW*NCH-1:0]      din_real;
  logic [DW*NCH-1:0]      din_imag;
  logic                   din_valid;
  logic [BEAT_BITS-1:0]   dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_first;
  logic                   dout_last;
  logic [5:0]             dout_chan;
  logic                   ovf_clr;
  logic                   overflow;
  logic [DCW-1:0]         drop_cnt;

  pfb_bin_serializer dut (
    .clk_data  (clk_data),
    .rst       (rst),
    .din_real  (din_real),
    .din_imag  (din_imag),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_first(dout_first),
    .dout_last (dout_last),
    .dout_chan (dout_chan),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk_data = 1'b0;
    forever #5 clk_data = ~clk_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of stored frames, beat index into the head frame.
  frame_t q[$];
  int     m_beat;
  bit     m_send;
  bit     m_ovf;
  int     m_drop;

  task automatic chk(input string nm, input v_t act, input v_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_beat = 0;
    m_send = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic mk_frame(input int tag, output frame_t f);
    for (int k = 0; k < NCH; k++) begin
      f.re[k] = DW'(tag * 256 + k);
      f.im[k] = -f.re[k];
    end
  endtask

  task automatic rnd_frame(output frame_t f);
    for (int k = 0; k < NCH; k++) begin
      f.re[k] = DW'($urandom);
      f.im[k] = DW'($urandom);
    end
  endtask

  task automatic check_outputs();
    logic [BEAT_BITS-1:0] exp;
    int idx;
    chk("dout_valid", v_t'(dout_valid), v_t'(m_send));
    if (m_send && q.size() > 0) begin
      exp = '0;
      for (int j = 0; j < BPB; j++) begin
        idx = m_beat * BPB + j;
        exp[j*2*DW +: 2*DW] = {q[0].im[idx], q[0].re[idx]};
      end
      chk("dout", v_t'(dout), v_t'(exp));
      chk("dout_first", v_t'(dout_first), v_t'(m_beat == 0));
      chk("dout_last", v_t'(dout_last), v_t'(m_beat == NB - 1));
      chk("dout_chan", v_t'(dout_chan), v_t'(m_beat * BPB));
    end
    chk("overflow", v_t'(overflow), v_t'(m_ovf));
    chk("drop_cnt", v_t'(drop_cnt), v_t'(m_drop));
  endtask

  // Called at a negedge: checks current outputs, drives inputs for the next
  // posedge, advances the model, returns at the following negedge.
  task automatic step(input frame_t f, input bit dv, input bit rdy, input bit clr);
    int had;
    bit fire, done, cap, drop;
    check_outputs();
    din_valid  = dv;
    dout_ready = rdy;
    ovf_clr    = clr;
    for (int k = 0; k < NCH; k++) begin
      din_real[k*DW +: DW] = f.re[k];
      din_imag[k*DW +: DW] = f.im[k];
    end
    had  = q.size();
    fire = m_send && rdy;
    done = fire && (m_beat == NB - 1);
    if (fire) begin
      if (done) begin
        q.delete(0);
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    cap  = dv && (had < 2 || done);
    drop = dv && !cap;
    if (cap) q.push_back(f);
    if (clr) begin
      m_ovf  = drop;
      m_drop = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    m_send = m_send ? (q.size() > 0) : (had > 0);
    @(posedge clk_data);
    @(negedge clk_data);
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    ovf_clr    = 1'b0;
    model_reset();
    @(negedge clk_data);
    @(negedge clk_data);
    rst = 1'b0;
  endtask

  row_t   tbl [28];
  frame_t fa, fb, fc, fx;
  int     nfirst;

  initial begin
    logic [BEAT_BITS-1:0] texp;
    logic [DW-1:0]        tre;

    // ev/ef/el/ch/etag are the expected outputs seen before the row's inputs apply.
    //          dv tag rdy ev ef el ch etag ovf drop
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 0, 0, 16, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 0, 32, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 1, 48, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 16, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 1, 0, 0, 16, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 32, 0, 0, 0};
    tbl[13] = '{0, 0, 1, 1, 0, 0, 32, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 1, 48, 0, 0, 0};
    tbl[15] = '{0, 0, 1, 1, 0, 1, 48, 0, 0, 0};
    tbl[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 3, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[19] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    tbl[20] = '{0, 0, 1, 1, 0, 0, 16, 1, 1, 1};
    tbl[21] = '{0, 0, 1, 1, 0, 0, 32, 1, 1, 1};
    tbl[22] = '{0, 0, 1, 1, 0, 1, 48, 1, 1, 1};
    tbl[23] = '{0, 0, 1, 1, 1, 0, 0, 2, 1, 1};
    tbl[24] = '{0, 0, 1, 1, 0, 0, 16, 2, 1, 1};
    tbl[25] = '{0, 0, 1, 1, 0, 0, 32, 2, 1, 1};
    tbl[26] = '{0, 0, 1, 1, 0, 1, 48, 2, 1, 1};
    tbl[27] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1};

    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    ovf_clr    = 1'b0;
    din_real   = '0;
    din_imag   = '0;
    model_reset();
    @(negedge clk_data);
    @(negedge clk_data);
    chk("rst_valid", v_t'(dout_valid), v_t'(0));
    chk("rst_dout", v_t'(dout), v_t'(0));
    chk("rst_first", v_t'(dout_first), v_t'(0));
    chk("rst_last", v_t'(dout_last), v_t'(0));
    chk("rst_chan", v_t'(dout_chan), v_t'(0));
    chk("rst_ovf", v_t'(overflow), v_t'(0));
    chk("rst_drop", v_t'(drop_cnt), v_t'(0));
    rst = 1'b0;

    // Single frame, stall pattern, then A/B buffered with C dropped.
    for (int i = 0; i < 28; i++) begin
      chk("tbl_valid", v_t'(dout_valid), v_t'(tbl[i].ev));
      if (tbl[i].ev != 0) begin
        chk("tbl_first", v_t'(dout_first), v_t'(tbl[i].ef));
        chk("tbl_last", v_t'(dout_last), v_t'(tbl[i].el));
        chk("tbl_chan", v_t'(dout_chan), v_t'(tbl[i].ch));
        for (int j = 0; j < BPB; j++) begin
          tre = DW'(tbl[i].etag * 256 + tbl[i].ch + j);
          texp[j*2*DW +: 2*DW] = {-tre, tre};
        end
        chk("tbl_dout", v_t'(dout), v_t'(texp));
      end
      chk("tbl_ovf", v_t'(overflow), v_t'(tbl[i].ovf));
      chk("tbl_drop", v_t'(drop_cnt), v_t'(tbl[i].drop));
      mk_frame(tbl[i].tag, fx);
      step(fx, tbl[i].dv != 0, tbl[i].rdy != 0, 1'b0);
    end

    // Full with last beat accepted in the same cycle as a new frame: no drop.
    apply_reset();
    mk_frame(4, fa); mk_frame(5, fb); mk_frame(6, fc);
    step(fa, 1, 0, 0);
    step(fb, 1, 0, 0);
    repeat (3) step(fa, 0, 1, 0);
    chk("bnd_last", v_t'(dout_last), v_t'(1));
    step(fc, 1, 1, 0);
    nfirst = 0;
    repeat (10) begin
      if (dout_valid && dout_first) nfirst++;
      step(fa, 0, 1, 0);
    end
    chk("bnd_frames", v_t'(nfirst), v_t'(2));
    chk("bnd_ovf", v_t'(overflow), v_t'(0));
    chk("bnd_drop", v_t'(drop_cnt), v_t'(0));

    // Saturating drop counter, clear, and clear coincident with a drop.
    apply_reset();
    step(fa, 1, 0, 0);
    step(fb, 1, 0, 0);
    repeat (65536) step(fc, 1, 0, 0);
    chk("sat_drop", v_t'(drop_cnt), v_t'(16'hFFFF));
    chk("sat_ovf", v_t'(overflow), v_t'(1));
    step(fc, 0, 0, 1);
    chk("clr_ovf", v_t'(overflow), v_t'(0));
    chk("clr_drop", v_t'(drop_cnt), v_t'(0));
    step(fc, 1, 0, 1);
    chk("clrdrop_ovf", v_t'(overflow), v_t'(1));
    chk("clrdrop_drop", v_t'(drop_cnt), v_t'(1));

    // Reset during beat 2 with a second frame buffered.
    apply_reset();
    step(fa, 1, 0, 0);
    step(fb, 1, 0, 0);
    step(fa, 0, 1, 0);
    step(fa, 0, 1, 0);
    chk("mid_chan", v_t'(dout_chan), v_t'(32));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", v_t'(dout_valid), v_t'(0));
    chk("mid_rst_dout", v_t'(dout), v_t'(0));
    chk("mid_rst_first", v_t'(dout_first), v_t'(0));
    chk("mid_rst_last", v_t'(dout_last), v_t'(0));
    chk("mid_rst_chan", v_t'(dout_chan), v_t'(0));
    model_reset();
    din_valid = 1'b0;
    @(negedge clk_data);
    @(negedge clk_data);
    rst = 1'b0;
    nfirst = 0;
    repeat (10) begin
      if (dout_valid) nfirst++;
      step(fa, 0, 1, 0);
    end
    chk("mid_no_beats", v_t'(nfirst), v_t'(0));
    step(fc, 1, 1, 0);
    repeat (6) step(fa, 0, 1, 0);

    // Randomized traffic against the model.
    repeat (3000) begin
      rnd_frame(fx);
      step(fx, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (12) step(fx, 0, 1, 0);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
